imm_decode_ctrl: RTL and testbench

Decode-stage sequencer for the immediate datapath. It accepts fetched instructions over a valid/ready handshake and buffers them in a small in-order queue. At enqueue it computes each instruction's format class and sign-extended immediate. It presents the oldest entry to dispatch over a second valid/ready handshake, with flush support for branch mispredict recovery.

---
 rtl/imm_decode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage queue for the immediate datapath.
// Fetched instructions are decoded (format class, sign-extended immediate)
// as they are enqueued, and the oldest entry is presented to dispatch.
// Optional macro IMM_JTYPE_EN adds the JAL / JALR / AUIPC decodes.
module imm_decode_ctrl #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
`ifdef IMM_JTYPE_EN
  localparam logic [2:0] FMT_J    = 3'd5;
`endif

  // Packs {illegal, fmt[2:0], imm[31:0]} for one instruction word.
  function automatic logic [35:0] decode(input logic [31:0] instr);
    logic signed [11:0] i12;
    logic signed [31:0] imm;
    logic [2:0]         fmt;
    logic               ill;
`ifdef IMM_JTYPE_EN
    logic signed [19:0] j20;
    j20 = '0;
`endif
    i12 = '0;
    imm = '0;
    fmt = FMT_NONE;
    ill = 1'b0;
    case (instr[6:0])
      7'b0010011, 7'b0000011: begin
        i12 = instr[31:20];
        imm = 32'(i12);
        fmt = FMT_I;
      end
      7'b0100011: begin
        i12 = {instr[31:25], instr[11:7]};
        imm = 32'(i12);
        fmt = FMT_S;
      end
      7'b1100011: begin
        // halfword offset, deliberately left unshifted
        i12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
        imm = 32'(i12);
        fmt = FMT_B;
      end
      7'b0110111: begin
        imm = {instr[31:12], 12'b0};
        fmt = FMT_U;
      end
      7'b0110011: begin
        fmt = FMT_NONE;
      end
`ifdef IMM_JTYPE_EN
      7'b1101111: begin
        j20 = {instr[31], instr[19:12], instr[20], instr[30:21]};
        imm = 32'(j20);
        fmt = FMT_J;
      end
      7'b1100111: begin
        i12 = instr[31:20];
        imm = 32'(i12);
        fmt = FMT_I;
      end
      7'b0010111: begin
        imm = {instr[31:12], 12'b0};
        fmt = FMT_U;
      end
`endif
      default: begin
        ill = 1'b1;
      end
    endcase
    return {ill, fmt, imm};
  endfunction

  logic [31:0]      mem_instr [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];
  logic [31:0]      mem_imm   [DEPTH];
  logic [2:0]       mem_fmt   [DEPTH];
  logic             mem_ill   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             enq;
  logic             deq;
  logic             vld_p0;
  logic [35:0]      dec_p0;

  // Handshake status depends on the registered count only.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  // ---- stage p0: decode at the queue input ----
  assign vld_p0 = enq;
  assign dec_p0 = decode(in_instr);

  // Write the decoded entry into the slot at wr_ptr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_tag[i]   <= '0;
        mem_imm[i]   <= '0;
        mem_fmt[i]   <= '0;
        mem_ill[i]   <= 1'b0;
      end
    end else if (vld_p0) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_tag[wr_ptr]   <= in_tag;
      mem_imm[wr_ptr]   <= dec_p0[31:0];
      mem_fmt[wr_ptr]   <= dec_p0[34:32];
      mem_ill[wr_ptr]   <= dec_p0[35];
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- head read: outputs forced to zero when the queue is empty ----
  always_comb begin
    out_instr   = '0;
    out_tag     = '0;
    out_imm     = '0;
    out_fmt     = FMT_NONE;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_instr   = mem_instr[rd_ptr];
      out_tag     = mem_tag[rd_ptr];
      out_imm     = mem_imm[rd_ptr];
      out_fmt     = mem_fmt[rd_ptr];
      out_illegal = mem_ill[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_imm_decode_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;

  int checks = 0;
  int errors = 0;

  imm_decode_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_tag(out_tag), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the opcode table, using integer sign handling.
  function automatic void mdl_decode(input logic [31:0] ins, output logic [31:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    int v;
    imm = 32'h0; fmt = 3'd0; ill = 1'b0; v = 0;
    case (ins[6:0])
      7'h13, 7'h03: begin v = ins[31:20]; if (v >= 2048) v -= 4096; imm = 32'(v); fmt = 3'd1; end
      7'h23: begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; imm = 32'(v); fmt = 3'd2; end
      7'h63: begin v = {ins[31], ins[7], ins[30:25], ins[11:8]}; if (v >= 2048) v -= 4096; imm = 32'(v); fmt = 3'd3; end
      7'h37: begin imm = ins & 32'hFFFF_F000; fmt = 3'd4; end
      7'h33: begin fmt = 3'd0; end
`ifdef IMM_JTYPE_EN
      7'h6F: begin v = {ins[31], ins[19:12], ins[20], ins[30:21]}; if (v >= (1 << 19)) v -= (1 << 20); imm = 32'(v); fmt = 3'd5; end
      7'h67: begin v = ins[31:20]; if (v >= 2048) v -= 4096; imm = 32'(v); fmt = 3'd1; end
      7'h17: begin imm = ins & 32'hFFFF_F000; fmt = 3'd4; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   m_enq, m_deq;

  // Reference queue: updated from the inputs seen at each rising edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
    end else begin
      m_enq = in_valid && (q.size() < DEPTH) && !flush;
      m_deq = (q.size() != 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (m_deq) void'(q.pop_front());
        if (m_enq) q.push_back('{instr: in_instr, tag: in_tag});
      end
    end
  end

  logic [31:0]      e_imm, e_instr;
  logic [2:0]       e_fmt;
  logic             e_ill, e_v;
  logic [TAG_W-1:0] e_tag;

  // Compare every output against the model at each falling edge.
  always @(negedge clk) begin
    e_v = (q.size() != 0);
    if (e_v) begin
      mdl_decode(q[0].instr, e_imm, e_fmt, e_ill);
      e_instr = q[0].instr;
      e_tag   = q[0].tag;
    end else begin
      e_imm = '0; e_fmt = '0; e_ill = 1'b0; e_instr = '0; e_tag = '0;
    end
    chk("m_out_valid", 64'(out_valid), 64'(e_v));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("m_out_instr", 64'(out_instr), 64'(e_instr));
    chk("m_out_tag", 64'(out_tag), 64'(e_tag));
    chk("m_out_imm", 64'(out_imm), 64'(e_imm));
    chk("m_out_fmt", 64'(out_fmt), 64'(e_fmt));
    chk("m_out_illegal", 64'(out_illegal), 64'(e_ill));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = t;
  endtask

  logic [31:0] p_imm;
  logic [2:0]  p_fmt;
  logic        p_ill;
  logic [31:0] r;
  logic [6:0]  ops [9];

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    ops = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h33, 7'h6F, 7'h67, 7'h17};

    // Pin the reference decoder with hand-computed values
    mdl_decode(32'hFFF00093, p_imm, p_fmt, p_ill);
    chk("pin_addi_imm", 64'(p_imm), 64'hFFFFFFFF);
    mdl_decode(32'hFE000CE3, p_imm, p_fmt, p_ill);
    chk("pin_b_imm", 64'(p_imm), 64'hFFFFFFFC);
    chk("pin_b_fmt", 64'(p_fmt), 64'd3);
    mdl_decode(32'hFFDFF06F, p_imm, p_fmt, p_ill);
`ifdef IMM_JTYPE_EN
    chk("pin_jal_imm", 64'(p_imm), 64'hFFFFFFFE);
    chk("pin_jal_fmt", 64'(p_fmt), 64'd5);
`else
    chk("pin_jal_ill", 64'(p_ill), 64'd1);
`endif

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    step();
    rstn = 1'b1;

    // Single addi -1 with dispatch ready
    out_ready = 1'b1;
    offer(32'hFFF00093, 6'd5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(out_fmt), 64'd1);
    chk("addi_tag", 64'(out_tag), 64'd5);
    step();
    @(negedge clk);
    chk("addi_drained", 64'(out_valid), 64'd0);

    // Back-to-back U, S, B
    offer(32'h123450B7, 6'd1);
    step();
    offer(32'hFE20AE23, 6'd2);
    @(negedge clk);
    chk("u_imm", 64'(out_imm), 64'h12345000);
    chk("u_fmt", 64'(out_fmt), 64'd4);
    chk("u_tag", 64'(out_tag), 64'd1);
    step();
    offer(32'hFE000CE3, 6'd3);
    @(negedge clk);
    chk("s_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("s_fmt", 64'(out_fmt), 64'd2);
    chk("s_tag", 64'(out_tag), 64'd2);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("b_fmt", 64'(out_fmt), 64'd3);
    chk("b_tag", 64'(out_tag), 64'd3);
    step();

    // Backpressure: fill, offer one more, then drain
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'h00100013 + (32'(i) << 20), 6'(10 + i));
      step();
    end
    offer(32'h00000033, 6'd63);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second_tag", 64'(out_tag), 64'd11);
    for (int i = 1; i < DEPTH; i++) step();
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two queued and an offered instruction
    out_ready = 1'b0;
    offer(32'h00500093, 6'd20);
    step();
    offer(32'h00600093, 6'd21);
    step();
    offer(32'h00700093, 6'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    @(negedge clk);
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // JAL with zero offset
    offer(32'h0000006F, 6'd7);
    step();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef IMM_JTYPE_EN
    chk("jal_fmt", 64'(out_fmt), 64'd5);
    chk("jal_ill", 64'(out_illegal), 64'd0);
`else
    chk("jal_fmt", 64'(out_fmt), 64'd0);
    chk("jal_ill", 64'(out_illegal), 64'd1);
`endif
    chk("jal_imm", 64'(out_imm), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset with one entry queued
    offer(32'h00A00093, 6'd9);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_instr", 64'(out_instr), 64'd0);
    chk("arst_out_imm", 64'(out_imm), 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    step();
    rstn = 1'b1;
    offer(32'h123450B7, 6'd33);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_imm", 64'(out_imm), 64'h12345000);
    step();

    // Randomized traffic checked by the model each cycle
    for (int c = 0; c < 2000; c++) begin
      r = $urandom();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) in_instr = {r[31:7], 7'($urandom_range(0, 127))};
      else in_instr = {r[31:7], ops[$urandom_range(0, 8)]};
      in_tag = 6'($urandom());
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
